mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  EX-stage multiply/divide unit; consumes the ID/EX pipeline register outputs (operands + decoded op).
//  Runs mult/multu/div/divu over a fixed multi-cycle latency; owns the HI/LO registers.
//  Drives busy back to the hazard unit, which asserts the ID/EX clear (stall) on a MD-class instr in ID.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy is high after a mult/multu start
//  DIV_CYCLES   10  cycles busy is high after a div/divu start
// PORTS
//  clk      in   1   system clock, all state on posedge
//  reset    in   1   synchronous, active-high
//  start    in   1   EX instr is mult/multu/div/divu (one-cycle pulse per instr)
//  MDU_op   in   4   op code from shared package (MDU_NONE..MDU_MFLO)
//  MDU_A    in   32  rs operand (forwarded IDEX_RD1)
//  MDU_B    in   32  rt operand (forwarded IDEX_RD2)
//  busy     out  1   operation in flight
//  HI       out  32  architectural HI
//  LO       out  32  architectural LO
//  MDU_Out  out  32  mfhi -> HI, mflo -> LO, else 0 (combinational)
// BEHAVIOUR
//  Reset: HI=0, LO=0, busy=0, counter=0, temp regs=0; in-flight op aborted, no commit.
//  Start accepted on posedge when start=1, busy=0, op in {MULT,MULTU,DIV,DIVU}:
//   - result captured into tmp_hi/tmp_lo from A,B at that edge; counter<=N; busy<=1.
//   - MULT: {tmp_hi,tmp_lo}=$signed(A)*$signed(B) (64b); MULTU unsigned 64b product.
//   - DIV: tmp_lo=quotient, tmp_hi=remainder, signed, truncate toward zero, rem sign=dividend.
//   - DIVU: same, unsigned.
//   - B==0 on DIV/DIVU: busy still runs DIV_CYCLES; HI/LO unchanged at commit.
//  Each posedge while busy: counter--; on edge where counter==1: busy<=0, HI<=tmp_hi, LO<=tmp_lo.
//  => busy high exactly N cycles after start edge; new HI/LO visible the cycle busy falls.
//  start while busy=1: ignored (hazard unit prevents it; bench asserts it never occurs).
//  MTHI/MTLO: HI (or LO) <= MDU_A on posedge when busy=0; ignored while busy=1.
//  MFHI/MFLO: read architectural HI/LO, no forwarding from tmp regs.
//  start=1 with op not MD-multi-cycle: no effect. MDU_NONE: no state change.
//  Stall contract (hazard unit, outside this block): stall = (start|busy) & ID instr MD-class.
//  Counter width = $clog2(max(MULT_CYCLES,DIV_CYCLES)+1); no wrap, saturates at 0.
// STRUCTURE
//  Shared package (mdu_defs): MDU_op encodings MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4,
//   MTHI=5, MTLO=6, MFHI=7, MFLO=8; default cycle counts; op width define.
//  Single module; no sub-module (compute is behavioural, latency modelled by counter FSM).
//  FSM: IDLE (busy=0) -> RUN on accepted start; RUN -> IDLE at counter==1 with commit; reset -> IDLE.
// TESTING
//  MULT A=0xFFFFFFFD(-3) B=5 -> busy high 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFF1.
//  MULTU A=0xFFFFFFFF B=2 -> after 5 cycles HI=0x00000001 LO=0xFFFFFFFE.
//  DIV A=0xFFFFFFF9(-7) B=2 -> busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/2 -> LO=3 HI=1.
//  HI=LO=0x12345678 preset via MTHI/MTLO, DIVU 7/0 -> busy 10 cycles, HI/LO stay 0x12345678.
//  MTHI 0xAAAA5555 issued while busy (mult in flight) -> ignored; HI = mult result at busy fall.
//  reset asserted 3 cycles into DIV -> next cycle busy=0, HI=LO=0, no later commit; MFLO -> 0.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies and a helper that classifies the multi-cycle operations.
package mdu_defs;

    localparam int MDU_OP_W        = 4;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    function automatic logic is_multi_cycle(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO. Results are computed at the
// start edge and committed after a fixed latency tracked by a down-counter.
module mult_div_unit
    import mdu_defs::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MDU_OP_W-1:0] MDU_op,
    input  logic [31:0]         MDU_A,
    input  logic [31:0]         MDU_B,
    output logic                busy,
    output logic [31:0]         HI,
    output logic [31:0]         LO,
    output logic [31:0]         MDU_Out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic             commit_en_q, commit_en_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quot_s, rem_s, quot_u, rem_u;
    logic        b_zero;

    assign b_zero = (MDU_B == 32'd0);

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    always_comb begin
        prod_s = {{32{MDU_A[31]}}, MDU_A} * {{32{MDU_B[31]}}, MDU_B};
        prod_u = {32'd0, MDU_A} * {32'd0, MDU_B};
        quot_s = 32'd0;
        rem_s  = 32'd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (!b_zero) begin
            quot_s = $signed(MDU_A) / $signed(MDU_B);
            rem_s  = $signed(MDU_A) % $signed(MDU_B);
            quot_u = MDU_A / MDU_B;
            rem_u  = MDU_A % MDU_B;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmp_hi_d    = tmp_hi_q;
        tmp_lo_d    = tmp_lo_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        commit_en_d = commit_en_q;
        case (state_q)
            S_IDLE: begin
                if (start && is_multi_cycle(MDU_op)) begin
                    state_d     = S_RUN;
                    commit_en_d = 1'b1;
                    case (MDU_op)
                        MDU_MULT: begin
                            {tmp_hi_d, tmp_lo_d} = prod_s;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        MDU_MULTU: begin
                            {tmp_hi_d, tmp_lo_d} = prod_u;
                            cnt_d = CNT_W'(MULT_CYCLES);
                        end
                        MDU_DIV: begin
                            tmp_hi_d    = rem_s;
                            tmp_lo_d    = quot_s;
                            cnt_d       = CNT_W'(DIV_CYCLES);
                            commit_en_d = !b_zero;
                        end
                        default: begin
                            tmp_hi_d    = rem_u;
                            tmp_lo_d    = quot_u;
                            cnt_d       = CNT_W'(DIV_CYCLES);
                            commit_en_d = !b_zero;
                        end
                    endcase
                end else if (MDU_op == MDU_MTHI) begin
                    hi_d = MDU_A;
                end else if (MDU_op == MDU_MTLO) begin
                    lo_d = MDU_A;
                end
            end
            default: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    if (commit_en_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tmp_hi_q    <= 32'd0;
            tmp_lo_q    <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            commit_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmp_hi_q    <= tmp_hi_d;
            tmp_lo_q    <= tmp_lo_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            commit_en_q <= commit_en_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        case (MDU_op)
            MDU_MFHI: MDU_Out = hi_q;
            MDU_MFLO: MDU_Out = lo_q;
            default:  MDU_Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO pairs are queued at issue
// and popped when busy falls.
module tb_mult_div_unit;
    import mdu_defs::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [MDU_OP_W-1:0] MDU_op;
    logic [31:0]         MDU_A, MDU_B;
    logic                busy;
    logic [31:0]         HI, LO, MDU_Out;

    int passed = 0;
    int total  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mult_div_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .MDU_op  (MDU_op),
        .MDU_A   (MDU_A),
        .MDU_B   (MDU_B),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .MDU_Out (MDU_Out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic simple_op(input logic [MDU_OP_W-1:0] op, input logic [31:0] a);
        MDU_op = op;
        MDU_A  = a;
        tick();
        MDU_op = MDU_NONE;
    endtask

    task automatic read_out(input string tag, input logic [MDU_OP_W-1:0] op, input logic [31:0] exp);
        MDU_op = op;
        #1;
        chk(tag, MDU_Out, exp);
        MDU_op = MDU_NONE;
    endtask

    // Issue one multi-cycle op; optionally drive MTHI mid-flight.
    task automatic run_md(input string name, input logic [MDU_OP_W-1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input int ecyc, input bit inject);
        int n;
        logic [63:0] e;
        chk({name, " busy_before"}, {31'd0, busy}, 32'd0);
        exp_q.push_back({ehi, elo});
        MDU_op = op; MDU_A = a; MDU_B = b; start = 1'b1;
        tick();
        start = 1'b0; MDU_op = MDU_NONE;
        chk({name, " busy_after_start"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 40) begin
            if (inject && n == 2) begin
                MDU_op = MDU_MTHI; MDU_A = 32'hAAAA5555;
            end else begin
                MDU_op = MDU_NONE;
            end
            tick();
            n++;
        end
        MDU_op = MDU_NONE;
        chk({name, " busy_cycles"}, n, ecyc);
        e = exp_q.pop_front();
        chk({name, " HI"}, HI, e[63:32]);
        chk({name, " LO"}, LO, e[31:0]);
        $display("txn %s op=%0d A=%08h B=%08h cycles=%0d HI=%08h LO=%08h", name, op, a, b, n, HI, LO);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; MDU_op = MDU_NONE; MDU_A = '0; MDU_B = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset HI", HI, 32'd0);
        chk("reset LO", LO, 32'd0);
        read_out("reset MFLO", MDU_MFLO, 32'd0);

        run_md("mult", MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 1'b0);
        read_out("mult MFHI", MDU_MFHI, 32'hFFFFFFFF);
        read_out("mult MFLO", MDU_MFLO, 32'hFFFFFFF1);

        run_md("multu", MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 1'b0);
        run_md("div", MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 1'b0);
        run_md("divu", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);

        simple_op(MDU_MTHI, 32'h12345678);
        simple_op(MDU_MTLO, 32'h12345678);
        chk("mthi HI", HI, 32'h12345678);
        chk("mtlo LO", LO, 32'h12345678);
        run_md("divu0", MDU_DIVU, 32'd7, 32'd0, 32'h12345678, 32'h12345678, 10, 1'b0);

        run_md("mult_mthi", MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b1);

        // start with a non-multi-cycle op must not launch anything
        MDU_op = MDU_MFHI; start = 1'b1;
        tick();
        start = 1'b0; MDU_op = MDU_NONE;
        chk("start_nonmd busy", {31'd0, busy}, 32'd0);
        chk("start_nonmd LO", LO, 32'd12);

        simple_op(MDU_MTHI, 32'hDEAD0001);
        chk("pre_reset HI", HI, 32'hDEAD0001);
        MDU_op = MDU_DIV; MDU_A = 32'd100; MDU_B = 32'd7; start = 1'b1;
        tick();
        start = 1'b0; MDU_op = MDU_NONE;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort HI", HI, 32'd0);
        chk("abort LO", LO, 32'd0);
        repeat (15) tick();
        chk("abort late HI", HI, 32'd0);
        chk("abort late LO", LO, 32'd0);
        read_out("abort MFLO", MDU_MFLO, 32'd0);
        $display("txn reset_abort HI=%08h LO=%08h busy=%0d", HI, LO, busy);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
